// File: rtl/mant_mul_arb.sv
// mant_mul_arb: round-robin sharing of one combinational mantissa multiplier between two
// requesters, with a single registered result slot returned over valid/ready.
module mant_mul_arb #(
  parameter int DWIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DWIDTH-1:0]     a0_i,
  input  logic [DWIDTH-1:0]     b0_i,
  input  logic                  valid0_i,
  output logic                  ready0_o,
  input  logic [DWIDTH-1:0]     a1_i,
  input  logic [DWIDTH-1:0]     b1_i,
  input  logic                  valid1_i,
  output logic                  ready1_o,
  output logic [DWIDTH-1:0]     mul_a_o,
  output logic [DWIDTH-1:0]     mul_b_o,
  input  logic [2*DWIDTH-1:0]   mul_res_i,
  output logic [2*DWIDTH-1:0]   res_o,
  output logic                  res_id_o,
  output logic                  res_valid_o,
  input  logic                  res_ready_i
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t              state_q, state_d;
  logic [2*DWIDTH-1:0] res_q, res_d;
  logic                id_q, id_d, last_q, last_d;
  logic                gnt, gnt_vld, free, acc;
  always_comb begin
    gnt_vld = valid0_i | valid1_i;
    gnt     = (valid0_i & valid1_i) ? !last_q : valid1_i;
    free    = (state_q == EMPTY) | res_ready_i;
    acc     = free & gnt_vld;
    state_d = acc ? FULL : ((state_q == FULL) & res_ready_i) ? EMPTY : state_q;
    res_d   = acc ? mul_res_i : res_q;
    id_d    = acc ? gnt : id_q;
    // priority rotates only on an actual handshake, never on a stalled grant
    last_d  = acc ? gnt : last_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      res_q   <= '0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end
  assign ready0_o    = acc & !gnt;
  assign ready1_o    = acc & gnt;
  assign mul_a_o     = !gnt_vld ? '0 : gnt ? a1_i : a0_i;
  assign mul_b_o     = !gnt_vld ? '0 : gnt ? b1_i : b0_i;
  assign res_o       = res_q;
  assign res_id_o    = id_q;
  assign res_valid_o = state_q == FULL;
endmodule

// File: doc/mant_mul_arb.md
# mant_mul_arb

Round-robin arbiter and sequencer that shares the single combinational `multiplier` mantissa datapath (DWIDTH × DWIDTH → 2·DWIDTH, unsigned) between two requesters. It sits between the two FP mantissa producers and the multiplier instance. It steers the granted operands onto the multiplier inputs and captures the product in one output register. It returns the product with a requester tag over a valid/ready handshake.

## Interface
- `DWIDTH`, 11, mantissa operand width (hidden bit included); product width is 2·DWIDTH.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `a0_i`, `b0_i`  in  DWIDTH each  requester 0 operands.
- `valid0_i`  in  1  requester 0 request.
- `ready0_o`  out  1  requester 0 accepted this cycle.
- `a1_i`, `b1_i`, `valid1_i`, `ready1_o`: same roles as the requester 0 signals, for requester 1.
- `mul_a_o`, `mul_b_o`  out  DWIDTH each  operands driven to the multiplier.
- `mul_res_i`  in  2·DWIDTH  multiplier product (combinational from `mul_a_o`/`mul_b_o`).
- `res_o`  out  2·DWIDTH  registered product.
- `res_id_o`  out  1  index of the requester that owns `res_o`.
- `res_valid_o`  out  1  `res_o`/`res_id_o` valid.
- `res_ready_i`  in  1  consumer accepts the result.

## Operation
- Internal state:
  - output register `res_q` (2·DWIDTH), `id_q`, `vld_q`;
  - round-robin pointer `last_q` (1 bit, id of the last granted requester).
- Output-stage FSM:
  - EMPTY (`vld_q`=0): EMPTY→FULL on accept.
  - FULL (`vld_q`=1):
    - FULL→EMPTY on drain (`res_valid_o & res_ready_i`) without accept.
    - FULL→FULL on drain+accept in the same cycle, or on stall.
- Slot free: `free = !vld_q | res_ready_i`.
- Grant (combinational):
  - Only one valid → grant it.
  - Both valid → grant `!last_q`.
  - None valid → no grant.
- Ready/accept:
  - `readyk_o = free & grant==k`; at most one ready high per cycle.
  - Accept = `valid & ready` of the granted requester.
- Steering:
  - `mul_a_o`/`mul_b_o` = granted requester's operands.
  - With no grant, drive all-zero (avoids toggling).
- On accept:
  - `res_q <= mul_res_i`, `id_q <= grant`, `vld_q <= 1`, `last_q <= grant`.
- On drain without accept: `vld_q <= 0`; `res_q`/`id_q` hold their last value.
- Arithmetic: full unsigned 2·DWIDTH product, no rounding or truncation; the arbiter never alters data.
- Requester protocol:
  - Once `validk_i` is high, `ak_i`/`bk_i` stay stable and valid stays high until `readyk_o`.
  - The arbiter does not check this.
- Work-conserving: a lone requester is granted every cycle the slot is free.
- `last_q` changes only on accept. A stalled grant does not rotate priority.

## Timing
- Reset (async, immediate on `rst_n`=0):
  - `res_valid_o`=0, `res_o`=0, `res_id_o`=0.
  - `last_q`=1, so requester 0 wins the first contention.
  - `ready0_o`/`ready1_o` follow the combinational rule: they may be high during reset if valid is high, but no state updates occur until `rst_n`=1.
- Latency:
  - Accept at edge N → `res_valid_o`=1 with the product after edge N.
  - One cycle from handshake to result.
- Throughput: one product per cycle while `res_ready_i`=1.
- Backpressure:
  - `res_valid_o`=1 & `res_ready_i`=0 → both readys low.
  - `res_o`/`res_id_o` held stable until drained.
- Combinational paths: `res_ready_i` → `readyk_o`, and `validk_i` → `readyk_o` / `mul_*_o`. There are no paths from `mul_res_i` to outputs.
- Simultaneous drain and accept: the new result replaces the old one in the same edge, with no bubble.
- Reset mid-operation: a pending result is discarded and no result is emitted after release.

## Test plan
- Reset, then `valid0_i`=1, `a0_i`=0x400, `b0_i`=0x400, `res_ready_i`=1:
  - `ready0_o`=1 in the same cycle, `mul_a_o`=0x400;
  - next cycle `res_valid_o`=1, `res_o`=0x100000, `res_id_o`=0.
- Both valid continuously with distinct operands, `res_ready_i`=1:
  - grants 0,1,0,1…, `res_id_o` alternates 0,1,0,1;
  - one result per cycle, each product matches its own operands.
- `res_ready_i`=0 after the first result:
  - `ready0_o`=`ready1_o`=0, `res_o` stable for 5 cycles;
  - raising `res_ready_i` drains and accepts the next request in the same cycle.
- Max operands 0x7FF × 0x7FF on requester 1 → `res_o`=0x3FF001, `res_id_o`=1.
- Only requester 1 valid for 4 back-to-back transactions → granted every cycle, 4 results with id 1, no idle cycles.
- Assert `rst_n`=0 while `res_valid_o`=1:
  - `res_valid_o`=0 immediately, before the next edge;
  - after release with both valid, requester 0 is granted first.
